// File: rtl/strassen_seq_ctrl_if.sv
// Control/address bundle between the Strassen sequencer (master) and the ALU/regfile datapath (slave).
// STRASSEN_SINGLE_STEP_EN adds the step input used by the single-step HOLD state.
interface strassen_seq_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [2:0]        alu_op;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] wa;
    logic              mem_we;
    logic [4:0]        op_idx;
`ifdef STRASSEN_SINGLE_STEP_EN
    logic              step;

    modport master (input start, input step, output busy, output done, output alu_op,
                    output ra, output rb, output wa, output mem_we, output op_idx);
    modport slave  (output start, output step, input busy, input done, input alu_op,
                    input ra, input rb, input wa, input mem_we, input op_idx);
`else
    modport master (input start, output busy, output done, output alu_op,
                    output ra, output rb, output wa, output mem_we, output op_idx);
    modport slave  (output start, input busy, input done, input alu_op,
                    input ra, input rb, input wa, input mem_we, input op_idx);
`endif
endinterface

// File: rtl/strassen_seq_ctrl.sv
// Sequencer for one 2x2 block Strassen multiply: steps a 25-op microprogram over a shared ALU/regfile.
// Optional macro STRASSEN_SINGLE_STEP_EN parks the FSM in HOLD after each write-back until step=1.
module strassen_seq_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int A_BASE  = 0,
    parameter int B_BASE  = 4,
    parameter int T_BASE  = 8,
    parameter int M_BASE  = 10,
    parameter int C_BASE  = 17,
    parameter int ADD_LAT = 1,
    parameter int MUL_LAT = 2
) (
    input logic                  clk,
    input logic                  rst,
    strassen_seq_ctrl_if.master  bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] EXEC = 3'd1;
    localparam logic [2:0] WB   = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
`ifdef STRASSEN_SINGLE_STEP_EN
    localparam logic [2:0] HOLD = 3'd4;
`endif

    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] d;
    } uop_t;

    // Operand symbols: 0-3 A11..A22, 4-7 B11..B22, 8-9 T0/T1, 10-16 M1..M7, 17-20 C11..C22
    function automatic uop_t uop(input logic [4:0] i);
        case (i)
            5'd0:    uop = {2'd0, 5'd0,  5'd3,  5'd8};
            5'd1:    uop = {2'd0, 5'd4,  5'd7,  5'd9};
            5'd2:    uop = {2'd2, 5'd8,  5'd9,  5'd10};
            5'd3:    uop = {2'd0, 5'd2,  5'd3,  5'd8};
            5'd4:    uop = {2'd2, 5'd8,  5'd4,  5'd11};
            5'd5:    uop = {2'd1, 5'd5,  5'd7,  5'd9};
            5'd6:    uop = {2'd2, 5'd0,  5'd9,  5'd12};
            5'd7:    uop = {2'd1, 5'd6,  5'd4,  5'd9};
            5'd8:    uop = {2'd2, 5'd3,  5'd9,  5'd13};
            5'd9:    uop = {2'd0, 5'd0,  5'd1,  5'd8};
            5'd10:   uop = {2'd2, 5'd8,  5'd7,  5'd14};
            5'd11:   uop = {2'd1, 5'd2,  5'd0,  5'd8};
            5'd12:   uop = {2'd0, 5'd4,  5'd5,  5'd9};
            5'd13:   uop = {2'd2, 5'd8,  5'd9,  5'd15};
            5'd14:   uop = {2'd1, 5'd1,  5'd3,  5'd8};
            5'd15:   uop = {2'd0, 5'd6,  5'd7,  5'd9};
            5'd16:   uop = {2'd2, 5'd8,  5'd9,  5'd16};
            5'd17:   uop = {2'd0, 5'd10, 5'd13, 5'd8};
            5'd18:   uop = {2'd1, 5'd8,  5'd14, 5'd8};
            5'd19:   uop = {2'd0, 5'd8,  5'd16, 5'd17};
            5'd20:   uop = {2'd0, 5'd12, 5'd14, 5'd18};
            5'd21:   uop = {2'd0, 5'd11, 5'd13, 5'd19};
            5'd22:   uop = {2'd1, 5'd10, 5'd11, 5'd8};
            5'd23:   uop = {2'd0, 5'd8,  5'd12, 5'd8};
            5'd24:   uop = {2'd0, 5'd8,  5'd15, 5'd20};
            default: uop = '0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] addr(input logic [4:0] s);
        int v;
        if (s < 5'd4)       v = A_BASE + int'(s);
        else if (s < 5'd8)  v = B_BASE + int'(s) - 4;
        else if (s < 5'd10) v = T_BASE + int'(s) - 8;
        else if (s < 5'd17) v = M_BASE + int'(s) - 10;
        else                v = C_BASE + int'(s) - 17;
        addr = ADDR_W'(v);
    endfunction

    // Counter holds remaining EXEC cycles minus one, so a latency of 1 leaves EXEC immediately.
    function automatic logic [CNT_W-1:0] lat_of(input logic [4:0] i);
        lat_of = (uop(i).op == 2'd2) ? CNT_W'(MUL_LAT - 1) : CNT_W'(ADD_LAT - 1);
    endfunction

    logic [2:0]       state;
    logic [4:0]       idx;
    logic [CNT_W-1:0] lat_cnt;
    uop_t             cur;

    assign cur = uop(idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            lat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state   <= EXEC;
                    idx     <= '0;
                    lat_cnt <= lat_of(5'd0);
                end
                EXEC: begin
                    if (lat_cnt == '0) state <= WB;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                WB: begin
                    if (idx == 5'd24) begin
                        state <= DONE;
                    end else begin
                        idx     <= idx + 5'd1;
                        lat_cnt <= lat_of(idx + 5'd1);
`ifdef STRASSEN_SINGLE_STEP_EN
                        state   <= HOLD;
`else
                        state   <= EXEC;
`endif
                    end
                end
`ifdef STRASSEN_SINGLE_STEP_EN
                HOLD: if (bus.step) begin
                    state   <= EXEC;
                    lat_cnt <= lat_of(idx);
                end
`endif
                DONE: begin
                    state <= IDLE;
                    idx   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.alu_op = '0;
        bus.ra     = '0;
        bus.rb     = '0;
        bus.wa     = '0;
        bus.mem_we = 1'b0;
        bus.op_idx = '0;
        case (state)
            EXEC, WB: begin
                bus.busy   = 1'b1;
                bus.alu_op = {1'b0, cur.op};
                bus.ra     = addr(cur.a);
                bus.rb     = addr(cur.b);
                bus.op_idx = idx;
                if (state == WB) begin
                    bus.mem_we = 1'b1;
                    bus.wa     = addr(cur.d);
                end
            end
`ifdef STRASSEN_SINGLE_STEP_EN
            HOLD: begin
                bus.busy   = 1'b1;
                bus.op_idx = idx;
            end
`endif
            DONE: bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_strassen_seq_ctrl.sv
// Directed bench for strassen_seq_ctrl: default, slow-ALU and relocated-base instances side by side.
// With STRASSEN_SINGLE_STEP_EN defined only the single-step sequence is exercised.
module tb_strassen_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    strassen_seq_ctrl_if #(.ADDR_W(5)) bus0 ();
    strassen_seq_ctrl_if #(.ADDR_W(5)) bus1 ();
    strassen_seq_ctrl_if #(.ADDR_W(5)) bus2 ();

    strassen_seq_ctrl #(.ADDR_W(5)) u0 (.clk(clk), .rst(rst0), .bus(bus0));
    strassen_seq_ctrl #(.ADDR_W(5), .ADD_LAT(2), .MUL_LAT(4)) u1 (.clk(clk), .rst(rst1), .bus(bus1));
    strassen_seq_ctrl #(.ADDR_W(5), .A_BASE(16), .B_BASE(20), .T_BASE(24), .M_BASE(0), .C_BASE(8))
        u2 (.clk(clk), .rst(rst2), .bus(bus2));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] alu_op;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] wa;
        logic       mem_we;
        logic [4:0] op_idx;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } vec_t;

    obs_t obs [3];
    assign obs[0] = {bus0.busy, bus0.done, bus0.alu_op, bus0.ra, bus0.rb, bus0.wa, bus0.mem_we, bus0.op_idx};
    assign obs[1] = {bus1.busy, bus1.done, bus1.alu_op, bus1.ra, bus1.rb, bus1.wa, bus1.mem_we, bus1.op_idx};
    assign obs[2] = {bus2.busy, bus2.done, bus2.alu_op, bus2.ra, bus2.rb, bus2.wa, bus2.mem_we, bus2.op_idx};

    int nvec = 0;
    int nbad = 0;

    vec_t tab[$];
    int   wq[$];
    int   ndone, done_cyc, nbusy, mul_runs, mul_min, mul_max;
    obs_t o_c1, o_c2;
    int   exp_wa [25] = '{8, 9, 10, 8, 11, 9, 12, 9, 13, 8, 14, 8, 9, 15, 8, 9, 16, 8, 8, 17, 18, 19, 8, 8, 20};

    function automatic obs_t mk(int b, int d, int a, int ra, int rb, int wa, int we, int ix);
        mk = {1'(b), 1'(d), 3'(a), 5'(ra), 5'(rb), 5'(wa), 1'(we), 5'(ix)};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got busy=%0d done=%0d op=%0d ra=%0d rb=%0d wa=%0d we=%0d idx=%0d, want busy=%0d done=%0d op=%0d ra=%0d rb=%0d wa=%0d we=%0d idx=%0d",
                     name, act.busy, act.done, act.alu_op, act.ra, act.rb, act.wa, act.mem_we, act.op_idx,
                     exp.busy, exp.done, exp.alu_op, exp.ra, exp.rb, exp.wa, exp.mem_we, exp.op_idx);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       bus0.start = v;
            1:       bus1.start = v;
            default: bus2.start = v;
        endcase
    endtask

    task automatic check_wa_seq(input string name);
        int first_bad = -1;
        for (int i = 0; i < 25 && i < wq.size(); i++)
            if (wq[i] != exp_wa[i] && first_bad < 0) first_bad = i;
        nvec++;
        if (first_bad >= 0) begin
            nbad++;
            $display("FAIL %s: write %0d got wa=%0d, want %0d", name, first_bad, wq[first_bad], exp_wa[first_bad]);
        end
    endtask

    // Start in cycle 0, observe cycles 1..ncyc; extra start pulses at cycles s1/s2 (-1 = none).
    task automatic run_seq(input int sel, input int ncyc, input int s1, input int s2, input bit use_tab);
        obs_t o, prev;
        int   run;
        wq.delete();
        ndone = 0; done_cyc = -1; nbusy = 0;
        mul_runs = 0; mul_min = 1000; mul_max = 0; run = 0;
        prev = '0;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                @(negedge clk);
                set_start(sel, (c == s1) || (c == s2));
            end
            o = obs[sel];
            if (c == 1) o_c1 = o;
            if (c == 2) o_c2 = o;
            if (o.mem_we) wq.push_back(int'(o.wa));
            if (o.done) begin ndone++; done_cyc = c; end
            if (o.busy) nbusy++;
            if (o.busy && !o.mem_we && o.alu_op == 3'd2 && (run == 0 || (o.ra == prev.ra && o.rb == prev.rb))) begin
                run++;
            end else if (run > 0) begin
                mul_runs++;
                if (run < mul_min) mul_min = run;
                if (run > mul_max) mul_max = run;
                run = (o.busy && !o.mem_we && o.alu_op == 3'd2) ? 1 : 0;
            end
            prev = o;
            if (use_tab)
                foreach (tab[k])
                    if (tab[k].cyc == c) check_obs($sformatf("seq cycle %0d", c), o, tab[k].exp);
        end
        set_start(sel, 1'b0);
    endtask

    initial begin
        obs_t o;
        int   bad_wr, nd, nb;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
`ifdef STRASSEN_SINGLE_STEP_EN
        bus0.step = 1'b0; bus1.step = 1'b0; bus2.step = 1'b0;
`endif
        tab.push_back('{0,  mk(0, 0, 0, 0, 0,  0,  0, 0)});
        tab.push_back('{1,  mk(1, 0, 0, 0, 3,  0,  0, 0)});
        tab.push_back('{2,  mk(1, 0, 0, 0, 3,  8,  1, 0)});
        tab.push_back('{3,  mk(1, 0, 0, 4, 7,  0,  0, 1)});
        tab.push_back('{5,  mk(1, 0, 2, 8, 9,  0,  0, 2)});
        tab.push_back('{6,  mk(1, 0, 2, 8, 9,  0,  0, 2)});
        tab.push_back('{7,  mk(1, 0, 2, 8, 9,  10, 1, 2)});
        tab.push_back('{25, mk(1, 0, 2, 8, 7,  0,  0, 10)});
        tab.push_back('{27, mk(1, 0, 2, 8, 7,  14, 1, 10)});
        tab.push_back('{56, mk(1, 0, 0, 8, 15, 0,  0, 24)});
        tab.push_back('{57, mk(1, 0, 0, 8, 15, 20, 1, 24)});
        tab.push_back('{58, mk(0, 1, 0, 0, 0,  0,  0, 0)});
        tab.push_back('{59, mk(0, 0, 0, 0, 0,  0,  0, 0)});

        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) check_obs($sformatf("reset dut%0d", s), obs[s], '0);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        repeat (2) @(negedge clk);

`ifdef STRASSEN_SINGLE_STEP_EN
        begin
            int nsteps, nwr;
            bit fin;
            bus0.start = 1'b1;
            @(negedge clk); bus0.start = 1'b0;
            check_obs("step op0 exec", obs[0], mk(1, 0, 0, 0, 3, 0, 0, 0));
            @(negedge clk);
            check_obs("step op0 wb", obs[0], mk(1, 0, 0, 0, 3, 8, 1, 0));
            @(negedge clk);
            check_obs("hold entry", obs[0], mk(1, 0, 0, 0, 0, 0, 0, 1));
            nb = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (obs[0] !== mk(1, 0, 0, 0, 0, 0, 0, 1)) nb++;
            end
            check_int("hold parked cycles off", nb, 0);
            bus0.step = 1'b1;
            @(negedge clk); bus0.step = 1'b0;
            check_obs("step op1 exec", obs[0], mk(1, 0, 0, 4, 7, 0, 0, 1));
            nsteps = 1; nwr = 1; nd = 0; fin = 1'b0;
            for (int c = 0; c < 400 && !fin; c++) begin
                @(negedge clk);
                bus0.step = 1'b0;
                o = obs[0];
                if (o.mem_we) nwr++;
                if (o.done) begin nd++; fin = 1'b1; end
                if (o.busy && !o.mem_we && o.alu_op == 3'd0 && o.ra == 5'd0 && o.rb == 5'd0) begin
                    bus0.step = 1'b1;
                    nsteps++;
                end
            end
            bus0.step = 1'b0;
            check_int("step done seen", nd, 1);
            check_int("step pulses", nsteps, 24);
            check_int("step writes", nwr, 25);
            check_obs("step done outputs", o, mk(0, 1, 0, 0, 0, 0, 0, 0));
            @(negedge clk);
            check_obs("step idle after", obs[0], '0);
            check_obs("step dut1 idle", obs[1], '0);
        end
`else
        // Default timing table, write order and totals.
        run_seq(0, 62, -1, -1, 1'b1);
        check_wa_seq("default wa order");
        check_int("default writes", wq.size(), 25);
        check_int("default done count", ndone, 1);
        check_int("default done cycle", done_cyc, 58);
        check_int("default busy cycles", nbusy, 57);
        check_int("default mult exec runs", mul_runs * 10000 + mul_min * 100 + mul_max, 7 * 10000 + 2 * 100 + 2);

        // Stray starts while busy and in DONE.
        run_seq(0, 62, 20, 58, 1'b0);
        check_int("stray start writes", wq.size(), 25);
        check_int("stray start done count", ndone, 1);
        check_int("stray start done cycle", done_cyc, 58);
        repeat (3) @(negedge clk);
        check_obs("idle after stray", obs[0], '0);

        // Restart, then reset during EXEC of op 10.
        bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        check_obs("restart op0", obs[0], mk(1, 0, 0, 0, 3, 0, 0, 0));
        repeat (24) @(negedge clk);
        check_obs("op10 exec before rst", obs[0], mk(1, 0, 2, 8, 7, 0, 0, 10));
        rst0 = 1'b1;
        #1;
        check_obs("outputs under rst", obs[0], '0);
        @(negedge clk); rst0 = 1'b0;
        bad_wr = 0; nd = 0; nb = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (obs[0].mem_we) bad_wr++;
            if (obs[0].done) nd++;
            if (obs[0].busy) nb++;
        end
        check_int("writes after abort", bad_wr, 0);
        check_int("done after abort", nd, 0);
        check_int("busy after abort", nb, 0);

        run_seq(0, 62, -1, -1, 1'b1);
        check_wa_seq("post-abort wa order");
        check_int("post-abort done count", ndone, 1);

        // Slow ALU instance.
        run_seq(1, 95, -1, -1, 1'b0);
        check_int("slow busy cycles", nbusy, 89);
        check_int("slow done cycle", done_cyc, 90);
        check_int("slow done count", ndone, 1);
        check_int("slow writes", wq.size(), 25);
        check_wa_seq("slow wa order");
        check_int("slow mult exec runs", mul_runs * 10000 + mul_min * 100 + mul_max, 7 * 10000 + 4 * 100 + 4);

        // Relocated bases.
        run_seq(2, 62, -1, -1, 1'b0);
        check_obs("reloc op0 exec", o_c1, mk(1, 0, 0, 16, 19, 0, 0, 0));
        check_obs("reloc op0 wb", o_c2, mk(1, 0, 0, 16, 19, 24, 1, 0));
        check_int("reloc writes", wq.size(), 25);
        check_int("reloc last wa", (wq.size() > 0) ? wq[wq.size() - 1] : -1, 11);
        check_int("reloc done cycle", done_cyc, 58);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
